// File: rtl/cflog_reader.sv
// Drains the CF-Log as a byte frame: SYNC_BYTE, N low/high, then N words low byte first.
// Define CFLOG_READER_CRC_EN to append a CRC-8 (poly 0x07) over all bytes after SYNC_BYTE.
module cflog_reader #(
    parameter logic [15:0] LOG_WORDS = 16'h0100,
    parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        flush,
    input  logic [15:0] cflow_log_ptr,
    output logic        log_rd_en,
    output logic [15:0] log_rd_addr,
    input  logic [15:0] log_rd_data,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    input  logic        tx_ready,
    output logic        busy,
    output logic        done
);

    typedef enum logic [3:0] {
        IDLE,
        HDR,
        CNT_LO,
        CNT_HI,
        READ,
        WAIT,
        SEND_LO,
        SEND_HI,
`ifdef CFLOG_READER_CRC_EN
        CRC,
`endif
        FIN
    } state_t;

`ifdef CFLOG_READER_CRC_EN
    localparam state_t LAST_STATE = CRC;
`else
    localparam state_t LAST_STATE = FIN;
`endif

    state_t      state_q, state_d;
    logic [15:0] idx_q, idx_d;
    logic [15:0] n_q, n_d;
    logic [15:0] word_q, word_d;
    logic [7:0]  tx_data_q, tx_data_d;
    logic [15:0] log_rd_addr_q, log_rd_addr_d;
    logic        tx_valid_q, tx_valid_d;
    logic        log_rd_en_q, log_rd_en_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        accept;

`ifdef CFLOG_READER_CRC_EN
    logic [7:0]  crc_q, crc_d, crc_next;

    function automatic logic [7:0] crc8_update(input logic [7:0] crc, input logic [7:0] data);
        logic [7:0] c;
        c = crc ^ data;
        for (int i = 0; i < 8; i++) begin
            c = c[7] ? ({c[6:0], 1'b0} ^ 8'h07) : {c[6:0], 1'b0};
        end
        return c;
    endfunction
`endif

    assign accept = tx_valid_q & tx_ready;

    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        n_d           = n_q;
        word_d        = word_q;
        tx_data_d     = tx_data_q;
        log_rd_addr_d = log_rd_addr_q;
`ifdef CFLOG_READER_CRC_EN
        crc_next      = crc8_update(crc_q, tx_data_q);
        crc_d         = crc_q;
`endif
        case (state_q)
            IDLE: if (flush) begin
                n_d       = (cflow_log_ptr > LOG_WORDS) ? LOG_WORDS : cflow_log_ptr;
                idx_d     = 16'h0000;
                tx_data_d = SYNC_BYTE;
`ifdef CFLOG_READER_CRC_EN
                crc_d     = 8'h00;
`endif
                state_d   = HDR;
            end
            HDR: if (accept) begin
                tx_data_d = n_q[7:0];
                state_d   = CNT_LO;
            end
            CNT_LO: if (accept) begin
`ifdef CFLOG_READER_CRC_EN
                crc_d     = crc_next;
`endif
                tx_data_d = n_q[15:8];
                state_d   = CNT_HI;
            end
            CNT_HI: if (accept) begin
`ifdef CFLOG_READER_CRC_EN
                crc_d     = crc_next;
                tx_data_d = crc_next;
`endif
                if (n_q != 16'h0000) begin
                    log_rd_addr_d = idx_q;
                    state_d       = READ;
                end else begin
                    state_d       = LAST_STATE;
                end
            end
            READ: state_d = WAIT;
            WAIT: begin
                word_d    = log_rd_data;
                tx_data_d = log_rd_data[7:0];
                state_d   = SEND_LO;
            end
            SEND_LO: begin
                tx_data_d = accept ? word_q[15:8] : word_q[7:0];
`ifdef CFLOG_READER_CRC_EN
                if (accept) crc_d = crc_next;
`endif
                if (accept) state_d = SEND_HI;
            end
            SEND_HI: if (accept) begin
`ifdef CFLOG_READER_CRC_EN
                crc_d     = crc_next;
                tx_data_d = crc_next;
`endif
                // idx stays on the last word so it never reaches LOG_WORDS
                if (idx_q + 16'd1 == n_q) begin
                    state_d       = LAST_STATE;
                end else begin
                    idx_d         = idx_q + 16'd1;
                    log_rd_addr_d = idx_q + 16'd1;
                    state_d       = READ;
                end
            end
`ifdef CFLOG_READER_CRC_EN
            CRC: if (accept) state_d = FIN;
`endif
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase

        tx_valid_d = (state_d == HDR) || (state_d == CNT_LO) || (state_d == CNT_HI) ||
                     (state_d == SEND_LO) || (state_d == SEND_HI)
`ifdef CFLOG_READER_CRC_EN
                     || (state_d == CRC)
`endif
                     ;
        log_rd_en_d = (state_d == READ);
        busy_d      = (state_d != IDLE);
        done_d      = (state_d == FIN);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            idx_q         <= 16'h0000;
            n_q           <= 16'h0000;
            word_q        <= 16'h0000;
            tx_data_q     <= 8'h00;
            log_rd_addr_q <= 16'h0000;
            tx_valid_q    <= 1'b0;
            log_rd_en_q   <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
`ifdef CFLOG_READER_CRC_EN
            crc_q         <= 8'h00;
`endif
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            n_q           <= n_d;
            word_q        <= word_d;
            tx_data_q     <= tx_data_d;
            log_rd_addr_q <= log_rd_addr_d;
            tx_valid_q    <= tx_valid_d;
            log_rd_en_q   <= log_rd_en_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
`ifdef CFLOG_READER_CRC_EN
            crc_q         <= crc_d;
`endif
        end
    end

    assign tx_valid    = tx_valid_q;
    assign tx_data     = tx_data_q;
    assign log_rd_en   = log_rd_en_q;
    assign log_rd_addr = log_rd_addr_q;
    assign busy        = busy_q;
    assign done        = done_q;

endmodule
